// File: rtl/hex_keypad_entry.sv
// 4x4 hex keypad scanner with debounce; accepted digits shift into a 16-bit entry register
// exported as a 32-bit MMIO/loopback value, plus a one-cycle key event per press.
module hex_keypad_entry #(
    parameter int SCAN_DIV = 1000,
    parameter int DEBOUNCE = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  row_in,
    output logic [3:0]  col_out,
    input  logic        clear,
    output logic [31:0] value_out,
    output logic        key_valid,
    output logic [3:0]  key_code,
    output logic [2:0]  digit_count
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int FW    = $clog2(DEBOUNCE + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [FW-1:0]    DEB_N    = FW'(DEBOUNCE);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRESS = 2'd1,
        HELD  = 2'd2
    } state_t;

    logic [3:0]       row_meta;
    logic [3:0]       row_sync;
    logic [DIV_W-1:0] div;
    logic [1:0]       col_idx;
    logic             sample;
    logic             frame_end;

    logic [1:0] acc_cnt;
    logic [3:0] acc_code;
    logic [2:0] col_hits;
    logic [1:0] col_row;
    logic [2:0] tot;
    logic [3:0] frame_code;
    logic       frame_empty;
    logic       frame_single;

    state_t     state, state_next;
    logic [FW-1:0] fcnt, fcnt_next;
    logic [3:0] cand, cand_next;
    logic       accept;

    logic [15:0] value;

    // Rows idle high through external pull-ups, so the synchronizer resets to "no key".
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_meta <= 4'hF;
            row_sync <= 4'hF;
        end else begin
            row_meta <= row_in;
            row_sync <= row_meta;
        end
    end

    assign sample    = (div == DIV_LAST);
    assign frame_end = sample && (col_idx == 2'd3);
    assign col_out   = ~(4'b0001 << col_idx);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div     <= '0;
            col_idx <= 2'd0;
        end else if (sample) begin
            div     <= '0;
            col_idx <= col_idx + 2'd1;
        end else begin
            div <= div + DIV_W'(1);
        end
    end

    always_comb begin
        col_hits = 3'd0;
        col_row  = 2'd0;
        for (int r = 0; r < 4; r++) begin
            if (!row_sync[r]) begin
                col_hits = col_hits + 3'd1;
                col_row  = 2'(r);
            end
        end
        tot          = {1'b0, acc_cnt} + col_hits;
        frame_code   = (col_hits != 3'd0) ? {col_row, col_idx} : acc_code;
        frame_empty  = (tot == 3'd0);
        frame_single = (tot == 3'd1);
    end

    // Per-frame running tally; a count of 2 already means MULTI, so it saturates there.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_cnt  <= 2'd0;
            acc_code <= 4'd0;
        end else if (sample) begin
            if (col_idx == 2'd3) begin
                acc_cnt  <= 2'd0;
                acc_code <= 4'd0;
            end else begin
                acc_cnt  <= (tot >= 3'd2) ? 2'd2 : tot[1:0];
                acc_code <= frame_code;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            fcnt  <= '0;
            cand  <= 4'd0;
        end else begin
            state <= state_next;
            fcnt  <= fcnt_next;
            cand  <= cand_next;
        end
    end

    always_comb begin
        state_next = state;
        fcnt_next  = fcnt;
        cand_next  = cand;
        accept     = 1'b0;
        if (frame_end) begin
            case (state)
                IDLE: begin
                    if (frame_single) begin
                        cand_next = frame_code;
                        if (DEB_N == FW'(1)) begin
                            accept     = 1'b1;
                            fcnt_next  = '0;
                            state_next = HELD;
                        end else begin
                            fcnt_next  = FW'(1);
                            state_next = PRESS;
                        end
                    end
                end
                PRESS: begin
                    if (!frame_single) begin
                        fcnt_next  = '0;
                        state_next = IDLE;
                    end else if (frame_code != cand) begin
                        cand_next = frame_code;
                        fcnt_next = FW'(1);
                    end else if (fcnt + FW'(1) == DEB_N) begin
                        accept     = 1'b1;
                        fcnt_next  = '0;
                        state_next = HELD;
                    end else begin
                        fcnt_next = fcnt + FW'(1);
                    end
                end
                HELD: begin
                    // fcnt here counts consecutive empty frames toward release.
                    if (!frame_empty) begin
                        fcnt_next = '0;
                    end else if (fcnt + FW'(1) == DEB_N) begin
                        fcnt_next  = '0;
                        state_next = IDLE;
                    end else begin
                        fcnt_next = fcnt + FW'(1);
                    end
                end
                default: begin
                    fcnt_next  = '0;
                    state_next = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_valid   <= 1'b0;
            key_code    <= 4'd0;
            value       <= 16'h0;
            digit_count <= 3'd0;
        end else begin
            key_valid <= accept;
            if (accept) begin
                key_code <= frame_code;
            end
            if (clear) begin
                value       <= 16'h0;
                digit_count <= 3'd0;
            end else if (accept) begin
                value       <= {value[11:0], frame_code};
                digit_count <= (digit_count == 3'd4) ? 3'd4 : digit_count + 3'd1;
            end
        end
    end

    assign value_out = {16'h0, value};

endmodule

// File: tb/tb_hex_keypad_entry.sv
// Directed bench for hex_keypad_entry: a keypad model drives the rows, the driver pushes
// expected key events into a queue and a negedge monitor pops and checks each pulse.
module tb_hex_keypad_entry;

    localparam int SCAN_DIV = 4;
    localparam int DEBOUNCE = 2;
    localparam int FRAME    = 4 * SCAN_DIV;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic [31:0] value_out;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [2:0]  digit_count;

    logic [15:0] keys;
    logic [22:0] exp_q[$];  // {value[15:0], digit_count[2:0], key_code[3:0]}
    logic [22:0] exp_item;
    logic [15:0] exp_value;
    logic [2:0]  exp_count;
    logic [3:0]  walk [5];
    int          checks = 0;
    int          errors = 0;
    int          pulses = 0;
    int          pulses_before;

    hex_keypad_entry #(
        .SCAN_DIV(SCAN_DIV),
        .DEBOUNCE(DEBOUNCE)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .row_in     (row_in),
        .col_out    (col_out),
        .clear      (clear),
        .value_out  (value_out),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .digit_count(digit_count)
    );

    always #5 clk = ~clk;

    // Keypad: row r is pulled low while column c is driven low and key 4r+c is down.
    always_comb begin
        row_in = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[4*r+c] && !col_out[c]) begin
                    row_in[r] = 1'b0;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic expect_accept(input logic [3:0] code, input logic clr);
        if (clr) begin
            exp_value = 16'h0;
            exp_count = 3'd0;
        end else begin
            exp_value = {exp_value[11:0], code};
            exp_count = (exp_count == 3'd4) ? 3'd4 : exp_count + 3'd1;
        end
        exp_q.push_back({exp_value, exp_count, code});
    endtask

    task automatic sync_frame();
        int n;
        n = 0;
        while (col_out !== 4'b0111 && n < 100) begin
            @(negedge clk);
            n++;
        end
        while (col_out !== 4'b1110 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("frame_sync", 32'(col_out), 32'h0000000E);
    endtask

    task automatic hold_frames(input int n);
        repeat (n * FRAME) @(negedge clk);
    endtask

    task automatic press_release(input int code, input int hold, input int rel);
        keys = '0;
        keys[code] = 1'b1;
        hold_frames(hold);
        keys = '0;
        hold_frames(rel);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 20 * FRAME) begin
            @(negedge clk);
            n++;
        end
        check("queue_drain", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin : monitor
        logic prev;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst && key_valid) begin
                pulses++;
                check("pulse_width", 32'(prev), 32'd0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pulse: key_code=%h value=%h, expected no pulse",
                             key_code, value_out);
                end else begin
                    exp_item = exp_q.pop_front();
                    check("pulse_code", 32'(key_code), 32'(exp_item[3:0]));
                    check("pulse_value", value_out, {16'h0, exp_item[22:7]});
                    check("pulse_count", 32'(digit_count), 32'(exp_item[6:4]));
                end
            end
            prev = key_valid;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL timeout: simulation did not complete, expected finish");
        $fatal(1, "timeout");
    end

    initial begin : driver
        walk[0] = 4'b1110;
        walk[1] = 4'b1101;
        walk[2] = 4'b1011;
        walk[3] = 4'b0111;
        walk[4] = 4'b1110;
        rst   = 1'b1;
        clear = 1'b0;
        keys  = '0;
        exp_value = 16'h0;
        exp_count = 3'd0;

        // Reset asserted mid-cycle takes effect immediately; then the column walk.
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (7) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_col_out", 32'(col_out), 32'h0000000E);
        check("rst_value", value_out, 32'h0);
        check("rst_count", 32'(digit_count), 32'd0);
        check("rst_key_valid", 32'(key_valid), 32'd0);
        check("rst_key_code", 32'(key_code), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("col_walk", 32'(col_out), 32'(walk[i]));
            repeat (4) @(negedge clk);
        end

        // Single press of key (1,2) held 6 frames; pulse one cycle after frame 2 ends.
        sync_frame();
        expect_accept(4'h6, 1'b0);
        keys = '0;
        keys[6] = 1'b1;
        repeat (2 * FRAME - 1) @(negedge clk);
        check("t2_before_pulse", 32'(key_valid), 32'd0);
        @(negedge clk);
        check("t2_pulse_time", 32'(key_valid), 32'd1);
        repeat (4 * FRAME) @(negedge clk);
        keys = '0;
        hold_frames(3);
        wait_drain();
        check("t2_value", value_out, 32'h00000006);
        check("t2_count", 32'(digit_count), 32'd1);
        check("t2_code", 32'(key_code), 32'd6);
        check("t2_pulses", 32'(pulses), 32'd1);

        // Sequence 1..5 overflows the four-digit register.
        sync_frame();
        for (int k = 1; k <= 5; k++) begin
            expect_accept(4'(k), 1'b0);
            press_release(k, 3, 3);
        end
        wait_drain();
        check("t3_value", value_out, 32'h00002345);
        check("t3_count", 32'(digit_count), 32'd4);
        check("t3_code", 32'(key_code), 32'd5);

        // Bounce: one frame of 0xA, then keys 3 and 7 alternating every frame.
        pulses_before = pulses;
        sync_frame();
        press_release(10, 1, 1);
        for (int i = 0; i < 6; i++) begin
            keys = '0;
            keys[(i % 2 == 0) ? 3 : 7] = 1'b1;
            hold_frames(1);
        end
        keys = '0;
        hold_frames(2);
        check("t4_no_pulse", 32'(pulses - pulses_before), 32'd0);
        check("t4_value", value_out, 32'h00002345);
        check("t4_count", 32'(digit_count), 32'd4);

        // Two keys together are rejected; then clear coincides with the accept of key 9.
        sync_frame();
        keys = '0;
        keys[0] = 1'b1;
        keys[5] = 1'b1;
        hold_frames(4);
        keys = '0;
        hold_frames(1);
        check("t5_multi_no_pulse", 32'(pulses - pulses_before), 32'd0);
        expect_accept(4'h9, 1'b1);
        keys[9] = 1'b1;
        repeat (2 * FRAME - 1) @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("t5_pulse", 32'(key_valid), 32'd1);
        check("t5_code", 32'(key_code), 32'd9);
        check("t5_value", value_out, 32'h0);
        repeat (FRAME) @(negedge clk);
        keys = '0;
        hold_frames(3);
        wait_drain();
        check("t5_value_after", value_out, 32'h0);
        check("t5_count_after", 32'(digit_count), 32'd0);

        // Reset during PRESS of key 0xF with the key still held afterwards.
        sync_frame();
        pulses_before = pulses;
        keys = '0;
        keys[15] = 1'b1;
        hold_frames(1);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        repeat (24) @(negedge clk);
        check("t6_in_rst_pulses", 32'(pulses - pulses_before), 32'd0);
        check("t6_in_rst_valid", 32'(key_valid), 32'd0);
        check("t6_in_rst_col", 32'(col_out), 32'h0000000E);
        exp_value = 16'h0;
        exp_count = 3'd0;
        expect_accept(4'hF, 1'b0);
        rst = 1'b0;
        repeat (2 * FRAME - 1) @(negedge clk);
        check("t6_before_pulse", 32'(key_valid), 32'd0);
        @(negedge clk);
        check("t6_pulse_time", 32'(key_valid), 32'd1);
        repeat (FRAME) @(negedge clk);
        keys = '0;
        hold_frames(3);
        wait_drain();
        check("t6_value", value_out, 32'h0000000F);
        check("t6_count", 32'(digit_count), 32'd1);
        check("t6_pulses", 32'(pulses - pulses_before), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hex_keypad_entry.md
# hex_keypad_entry

Input-side counterpart of the board's 7-segment hex display path. It scans a 4x4 hex matrix keypad, synchronizes and debounces key presses, and shifts each accepted hex digit into a 16-bit entry register. The register is exported as a 32-bit value for the core's MMIO input and for loopback to the display. It also emits a one-cycle key event per accepted press.

## Interface
- `SCAN_DIV`, default 1000: clock cycles each keypad column is driven. Legal range is ≥ 4.
- `DEBOUNCE`, default 4: consecutive identical scan frames required to accept a press or a release. Legal range is ≥ 1.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `row_in` in 4: keypad rows, active-low with external pull-ups, asynchronous to `clk`.
- `col_out` out 4: keypad column drive, active-low, exactly one bit low at any time.
- `clear` in 1: synchronous clear of the entry register and digit count.
- `value_out` out 32: bits [15:0] hold the entered digits, with the newest digit in [3:0]. Bits [31:16] are always 0.
- `key_valid` out 1: one-cycle pulse per accepted press.
- `key_code` out 4: code of the last accepted key, held between pulses.
- `digit_count` out 3: number of digits entered since reset or clear, saturating at 4.

## Operation
**Key code.** The key at row r, column c has code 4*r + c (r, c in 0..3).

**Input synchronizer.** `row_in` passes through a 2-flop synchronizer before any use.

**Column scan.**
- A divider counts 0..SCAN_DIV-1.
- A column index col_idx counts 0..3 and advances with wrap when the divider reaches SCAN_DIV-1.
- `col_out` = ~(4'b0001 << col_idx).

**Sampling.**
- The synchronized rows are sampled when the divider equals SCAN_DIV-1, before col_idx advances.
- Sampled row bit r low means key (r, col_idx) is pressed.
- One frame is 4 columns (4*SCAN_DIV cycles).
- The frame ends at the sample of column 3. Each frame is classified as:
  - EMPTY: no key pressed.
  - SINGLE(code): exactly one key pressed.
  - MULTI: two or more keys pressed.

**FSM.** State is evaluated only at frame end. It keeps a frame counter fcnt and a candidate code cand.
- **IDLE.**
  - SINGLE(k): cand = k, fcnt = 1, go to PRESS. If DEBOUNCE = 1, accept immediately and go to HELD.
  - EMPTY or MULTI: stay in IDLE.
- **PRESS.**
  - SINGLE(cand): fcnt+1. When fcnt reaches DEBOUNCE, accept and go to HELD.
  - SINGLE(other k): cand = k, fcnt = 1, stay in PRESS.
  - EMPTY or MULTI: go to IDLE.
- **HELD.**
  - EMPTY: fcnt+1. After DEBOUNCE consecutive EMPTY frames, go to IDLE.
  - Any non-EMPTY frame: fcnt = 0, stay in HELD. Holding a key or pressing a second key never produces a repeat.

**Accept.** In the cycle after the deciding frame end:
- `key_valid` = 1.
- `key_code` = cand.
- value[15:0] ← {value[11:0], cand}.
- `digit_count` ← min(`digit_count` + 1, 4).

**Clear.**
- `clear` sets value and `digit_count` to 0 on the next edge.
- If it coincides with an accept, the clear wins for value and `digit_count`. `key_valid` and `key_code` still update.
- `clear` has no effect on the scan or the FSM.

**Overflow.** The shift discards the oldest digit (bits [15:12]).

## Timing
**Reset values** (immediate, asynchronous):
- `col_out` = 4'b1110, divider = 0, col_idx = 0.
- FSM = IDLE, fcnt = 0, cand = 0.
- `key_valid` = 0, `key_code` = 0, `value_out` = 0, `digit_count` = 0.

**Key-to-sample latency.** 2 cycles through the synchronizer. The sample at divider = SCAN_DIV-1 therefore sees `row_in` as it stood at least SCAN_DIV-3 cycles after the column switched. This is why SCAN_DIV ≥ 4.

**Press latency.** `key_valid` rises 1 cycle after the frame end of the DEBOUNCE-th consecutive SINGLE frame. It lasts exactly 1 cycle. `value_out` and `digit_count` change on that same edge.

**Minimum spacing.** Two accepts are at least (2*DEBOUNCE)*4*SCAN_DIV cycles apart.

**Reset mid-operation.** Reset aborts any PRESS or HELD state with no pulse. After reset deasserts, a key still held is treated as a new press and is accepted after DEBOUNCE frames.

## Test plan
The bench uses SCAN_DIV = 4 and DEBOUNCE = 2. The keypad model pulls `row_in[r]` low while `col_out[c]` is low and key (r, c) is pressed.
1. **Reset.** Assert `rst` mid-cycle -> `col_out` = 1110, `value_out` = 0, `digit_count` = 0, `key_valid` = 0. After release, `col_out` walks 1110 → 1101 → 1011 → 0111 → 1110 every 4 cycles.
2. **Single press.** Hold key (1, 2) for 6 frames, then release for 3 frames -> exactly one `key_valid` pulse, `key_code` = 6, `value_out` = 0x00000006, `digit_count` = 1. The pulse comes 1 cycle after the end of frame 2.
3. **Sequence entry.** Press/release keys 1, 2, 3, 4, 5 (each held 3 frames, released 3 frames) -> five pulses, final `value_out` = 0x00002345, `digit_count` = 4.
4. **Bounce rejection.** Press key 0xA for 1 frame only, then release. Then alternate keys 3 and 7 on every frame -> no `key_valid`, `value_out` unchanged.
5. **Multi-key and clear.** Hold keys 0 and 5 together for 4 frames -> no pulse. Then `clear` pulses in the same cycle as a `key_valid` for code 9 -> `key_code` = 9, `value_out` = 0, `digit_count` = 0.
6. **Reset during PRESS.** After 1 SINGLE frame of key 0xF, assert `rst` and keep the key held -> no pulse during reset. After reset releases, one pulse (`key_code` = 0xF) after 2 frames.
